// File: rtl/lfsr_pkg.sv
// lfsr_pkg: FSM state encoding and standard maximal-length tap masks
// shared by the lfsr_gen block.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } lfsr_state_t;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;
    localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational Fibonacci LFSR advance by OUT_BITS single steps;
// each step shifts left and inserts the tap parity at bit 0.
module lfsr_step #(
    parameter int          WIDTH    = 64,
    parameter logic [63:0] TAPS     = 64'hD800_0000_0000_0000,
    parameter int          OUT_BITS = 1
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    localparam logic [WIDTH-1:0] MASK = TAPS[WIDTH-1:0];

    logic [WIDTH-1:0] s;

    always_comb begin
        s = state;
        for (int i = 0; i < OUT_BITS; i++) begin
            s = {s[WIDTH-2:0], ^(s & MASK)};
        end
        next_state = s;
    end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: seeded LFSR stream source with valid/ready output and beat counter.
// Define LFSR_LOCKUP_DETECT_EN to replace zero seeds with DEFAULT_SEED and flag them.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 64,
    parameter logic [63:0]      TAPS         = TAPS_64,
    parameter int               OUT_BITS     = 1,
    parameter int               CNT_W        = 32,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                seed_valid,
    input  logic [WIDTH-1:0]    seed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic [CNT_W-1:0]    beat_cnt,
    output logic                lockup_err
);

`ifdef LFSR_LOCKUP_DETECT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    lfsr_state_t      fsm, fsm_next;
    logic [WIDTH-1:0] state, stepped, load_seed;
    logic             accept, xfer, seed_zero;

    lfsr_step #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .OUT_BITS (OUT_BITS)
    ) u_step (
        .state      (state),
        .next_state (stepped)
    );

    // A seed arriving while the first beat is being primed is dropped.
    assign accept    = seed_valid && (fsm != PRIME);
    assign xfer      = out_valid && out_ready;
    assign seed_zero = (seed == '0);
    assign load_seed = (LOCK_EN && seed_zero) ? DEFAULT_SEED : seed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fsm <= IDLE;
        else        fsm <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (seed_valid) fsm_next = PRIME;
            PRIME:   fsm_next = RUN;
            RUN:     if (seed_valid) fsm_next = PRIME;
            default: fsm_next = IDLE;
        endcase
    end

    // Seed load has priority over a coinciding transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            beat_cnt  <= '0;
        end else if (accept) begin
            state     <= load_seed;
            out_valid <= 1'b0;
            beat_cnt  <= '0;
        end else if (fsm == PRIME) begin
            state     <= stepped;
            out_data  <= stepped[OUT_BITS-1:0];
            out_valid <= 1'b1;
        end else if (fsm == RUN && xfer) begin
            state     <= stepped;
            out_data  <= stepped[OUT_BITS-1:0];
            beat_cnt  <= beat_cnt + CNT_W'(1);
        end
    end

`ifdef LFSR_LOCKUP_DETECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lockup_err <= 1'b0;
        else        lockup_err <= accept && seed_zero;
    end
`else
    assign lockup_err = 1'b0;
`endif

endmodule
